// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Receive byte buffer between the UART receiver stream output
//               and the CSR data register. It never back-pressures. It has a
//               sticky overflow flag, a synchronous flush and a
//               threshold-based level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [7:0]    s_data_i,
    input  logic          s_valid_i,
    output logic          s_ready_o,
    input  logic          rd_strobe_i,
    output logic [7:0]    data_o,
    output logic          not_empty_o,
    output logic [CW-1:0] count_o,
    output logic          overflow_o,
    input  logic          clear_overflow_i,
    input  logic          flush_i,
    input  logic [CW-1:0] threshold_i,
    output logic          irq_o
);

    localparam int          c_AW    = $clog2(DEPTH);
    localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wp;
    logic [c_AW-1:0] r_rp;
    logic [CW-1:0]   r_count;
    logic            r_overflow;
    logic            r_irq;

    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [CW-1:0]   w_count_next;

    // Push/pop qualification. When the FIFO is full, a pop in the same cycle
    // frees the slot that the incoming byte takes.
    always_comb begin
        w_full       = (r_count == c_DEPTH);
        w_pop        = rd_strobe_i && (r_count != '0);
        w_push       = s_valid_i && (!w_full || w_pop);
        w_drop       = s_valid_i && w_full && !w_pop && !flush_i;
        w_count_next = r_count + {{(CW-1){1'b0}}, w_push}
                               - {{(CW-1){1'b0}}, w_pop};
        if (flush_i) begin
            w_count_next = '0;
        end
    end

    // Byte storage. It has no reset because reset only has to empty the
    // FIFO through the pointers and count.
    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i) begin
            r_mem[r_wp] <= s_data_i;
        end
    end

    // Pointers, occupancy and the registered interrupt level. A flush
    // overrides any push or pop in the same cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_irq   <= 1'b0;
        end else begin
            if (flush_i) begin
                r_wp <= '0;
                r_rp <= '0;
            end else begin
                if (w_push) begin
                    r_wp <= r_wp + 1'b1;
                end
                if (w_pop) begin
                    r_rp <= r_rp + 1'b1;
                end
            end
            r_count <= w_count_next;
            r_irq   <= (threshold_i != '0) && (w_count_next >= threshold_i);
        end
    end

    // Sticky overflow flag. A new drop takes priority over a clear in the
    // same cycle. A flush leaves the flag unchanged.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clear_overflow_i) begin
            r_overflow <= 1'b0;
        end
    end

    // Head byte is an asynchronous read. It is forced to zero while empty so
    // that the CSR never shows a stale byte.
    always_comb begin
        data_o = (r_count != '0) ? r_mem[r_rp] : 8'h00;
    end

    assign s_ready_o   = 1'b1;
    assign not_empty_o = (r_count != '0);
    assign count_o     = r_count;
    assign overflow_o  = r_overflow;
    assign irq_o       = r_irq;

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer between the UART receiver's AXI-Stream output and the CSR block's `UART_DATA` register. It accepts every byte the receiver presents without back-pressure, stores up to `DEPTH` bytes, and exposes the head byte, occupancy, a sticky overflow flag and a level-triggered interrupt request to `top_csr` and `Interrupt_Ctrl`. It removes the single-byte receive window, so the CPU can service the UART once per HSYNC/VSYNC interrupt without dropping characters.

## Interface

**Parameters**
- `DEPTH`, default 16: number of byte entries. Must be a power of two, minimum 2.
- `CW`, default `$clog2(DEPTH)+1`: width of the count and threshold fields. Derived; do not override.

**Ports**
- `clk_i` in 1: system clock, `clk_sys`.
- `rst_n_i` in 1: reset, asynchronous and active-low.
- `s_data_i` in 8: received byte from `uart.m_axis_tdata`.
- `s_valid_i` in 1: byte valid, from `uart.m_axis_tvalid`.
- `s_ready_o` out 1: tied to constant 1. Every presented byte is consumed in the same cycle, either stored or dropped.
- `rd_strobe_i` in 1: pop request, from `UART_DATA_rd_o`. Single-cycle strobe.
- `data_o` out 8: head byte. Reads 8'h00 when the FIFO is empty.
- `not_empty_o` out 1: FIFO holds at least one byte. Drives `UART_STATUS_RX_NOT_EMPTY_i`.
- `count_o` out CW: current occupancy, range 0..DEPTH.
- `overflow_o` out 1: sticky flag, set when a byte was dropped.
- `clear_overflow_i` in 1: clears `overflow_o`.
- `flush_i` in 1: empties the FIFO synchronously.
- `threshold_i` in CW: interrupt level. A value of 0 disables the interrupt.
- `irq_o` out 1: level request, asserted while `count_o >= threshold_i` and `threshold_i != 0`.

## Operation

- **Storage:** `DEPTH` x 8 array, with write pointer `wp` and read pointer `rp`, each `$clog2(DEPTH)` bits.
  - Pointers wrap modulo `DEPTH` through natural overflow.
  - Occupancy is held in a separate `CW`-bit counter.
- **Write:** when `s_valid_i=1` and either `count < DEPTH` or a pop occurs in the same cycle:
  - store `s_data_i` at `wp`;
  - increment `wp`.
- **Overflow:** when `s_valid_i=1`, `count == DEPTH` and no pop occurs:
  - the byte is dropped;
  - the FIFO contents are unchanged;
  - `overflow_o` is set.
- **Pop:** when `rd_strobe_i=1` and `count > 0`, increment `rp`. A strobe while empty is ignored, with no state change.
- **Simultaneous push and pop:** the count is unchanged and both pointers advance. This holds when full as well as in every other state.
- **Count update:** `count_next = count + push - pop`.
- **Flush:** `flush_i=1` has top priority.
  - Sets `wp`, `rp` and `count` to 0.
  - A push or pop in the same cycle is discarded.
  - A byte arriving in the flush cycle is lost without setting `overflow_o`.
  - `overflow_o` is not affected.
- **Overflow flag:** `clear_overflow_i` clears it. If a set and a clear occur in the same cycle, set wins.
- **Head output:** `data_o = (count != 0) ? mem[rp] : 8'h00`.
  - This is combinational from the registered `rp` and `count`.
  - Distributed RAM read is asynchronous.
- **Interrupt output:** `irq_o` is registered and computed from `count_next` and `threshold_i`. It tracks the occupancy the FIFO will have after the current cycle.
- **Reset mid-operation:** the FIFO returns to empty and all contents are discarded. Array contents need not be cleared.

## Timing

- **Reset values:**
  - `count_o = 0`
  - `not_empty_o = 0`
  - `data_o = 8'h00`
  - `overflow_o = 0`
  - `irq_o = 0`
  - `s_ready_o = 1`
- **Write latency:** a byte accepted at edge N is visible on `data_o`, with `not_empty_o=1` and `count_o` updated, after edge N+1.
- **Pop latency:** a pop strobed in cycle N advances `data_o` to the next byte, or to 8'h00 if the FIFO is now empty, after edge N+1.
- **CSR read (Wishbone):** a read in cycle N returns the `data_o` sampled in cycle N, i.e. the byte before the pop. `top_csr` samples `UART_DATA_DATA_i` and asserts `UART_DATA_rd_o` in the same cycle.
- **`irq_o` latency:** it changes on the same edge as `count_o`.
- **Back-to-back operation:** a push and a pop are each sustainable every cycle.

## Test plan

- **Ordering:** push 0x41, 0x42, 0x43 on consecutive cycles, then pop three times.
  - `data_o` reads 41, 42, 43, then 00.
  - `count_o` goes 3 → 0.
  - `not_empty_o` drops after the third pop.
- **Fill and overflow (DEPTH=16):** push 0x00..0x0F, then push 0xFF.
  - `count_o` stays at 16 and `overflow_o=1`.
  - Popping 16 bytes yields 0x00..0x0F; 0xFF is never seen.
  - Asserting `clear_overflow_i` returns `overflow_o` to 0.
- **Full with simultaneous push and pop:** with the FIFO full (0x00..0x0F), push 0x99 and pop in the same cycle.
  - `count_o` stays at 16 and `overflow_o` stays 0.
  - The head becomes 0x01.
  - The last of the 16 subsequent pops returns 0x99.
- **Flush:** with 5 bytes stored, assert `flush_i` in the same cycle as a push of 0x55 and a pop.
  - Next cycle: `count_o=0`, `data_o=00`, `not_empty_o=0`, `overflow_o` unchanged.
- **Interrupt threshold:** with `threshold_i=4`, push 4 bytes.
  - `irq_o` rises on the edge that makes `count_o=4`.
  - One pop deasserts it on the same edge that makes `count_o=3`.
  - With `threshold_i=0`, `irq_o` stays 0 at any occupancy.
- **Asynchronous reset mid-stream:** drop `rst_n_i` between clock edges with 7 bytes stored.
  - All outputs go to their reset values immediately, without a clock edge.
  - A pop strobed while the FIFO is empty after reset is ignored.
  - `count_o` remains 0.
